pipe_stage_reg: RTL and testbench

- Parametrised elastic pipeline register for inter-stage boundaries (EX/MEM, MEM/WB, ...) in the Sparcy pipeline.
- Replaces the fixed always-load stage register with a valid/ready stage that adds:
  - a 2-entry skid buffer, so `in_ready` is registered;
  - synchronous flush, which inserts a bubble;
  - NOP payload substitution whenever the stage holds no valid beat;
  - a saturating back-pressure counter.
- Payload is an opaque packed bus; the instantiating stage concatenates target, regD, alures, op fields, valD, etc.

---
 rtl/pipe_stage_reg.sv | 126 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic valid/ready pipeline register for inter-stage
// boundaries. A main register drives the output and a skid register absorbs
// one extra beat, so in_ready comes straight from a flop. Synchronous flush
// kills all held beats. While no beat is held, out_data shows NOP_PAYLOAD.
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   asynchronous active-high reset
//   flush         in   synchronous kill of all held beats
//   in_valid      in   upstream beat valid
//   in_data       in   upstream payload [DATA_W]
//   in_ready      out  stage can accept a beat (registered)
//   out_valid     out  stage presents a valid beat
//   out_data      out  presented payload, NOP_PAYLOAD when idle [DATA_W]
//   out_ready     in   downstream accepts the beat
//   occupancy     out  number of held beats, 0..2
//   stall_cnt     out  saturating count of stalled cycles [CNT_W]
//   stall_cnt_clr in   synchronous clear of stall_cnt
module pipe_stage_reg #(
    parameter int unsigned             DATA_W      = 32,
    parameter logic [DATA_W-1:0]       NOP_PAYLOAD = '0,
    parameter int unsigned             CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_cnt_clr
);

    // Encoding is {m_valid, s_valid}; the pair (0,1) has no state.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_TWO   = 2'b11
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic [DATA_W-1:0]   s_data_q, s_data_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

    logic m_valid, s_valid;
    logic accept, deliver;

    assign m_valid = state_q[1];
    assign s_valid = state_q[0];

    assign in_ready  = ~s_valid;
    assign out_valid = m_valid;
    assign out_data  = m_valid ? m_data_q : NOP_PAYLOAD;
    assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};
    assign stall_cnt = stall_cnt_q;

    assign accept  = in_valid & in_ready;
    assign deliver = m_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            m_data_q    <= '0;
            s_data_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            m_data_q    <= m_data_d;
            s_data_q    <= s_data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Data registers only change on the listed transitions; a flush empties
    // the stage but leaves the payload registers untouched.
    always_comb begin
        state_d  = state_q;
        m_data_d = m_data_q;
        s_data_d = s_data_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        m_data_d = in_data;
                        state_d  = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (deliver && accept) begin
                        m_data_d = in_data;
                    end else if (deliver) begin
                        state_d = ST_EMPTY;
                    end else if (accept) begin
                        s_data_d = in_data;
                        state_d  = ST_TWO;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only the skid can refill main.
                    if (deliver) begin
                        m_data_d = s_data_q;
                        state_d  = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_cnt_clr) begin
            stall_cnt_d = '0;
        end else if (m_valid && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: directed stimulus pushes each accepted beat
// into a scoreboard queue; an independent monitor pops and compares on every
// delivery, and checks the idle-output invariants every cycle.
module tb_pipe_stage_reg;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 3;
    localparam logic [DW-1:0] NOP = 8'h00;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cnt;
    logic          stall_cnt_clr;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] sb_q[$];

    pipe_stage_reg #(
        .DATA_W     (DW),
        .NOP_PAYLOAD(NOP),
        .CNT_W      (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .occupancy    (occupancy),
        .stall_cnt    (stall_cnt),
        .stall_cnt_clr(stall_cnt_clr)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Drive one cycle of inputs just after an edge, log the beat if it will be
    // accepted, then advance past the next edge.
    task automatic beat(input logic v, input logic [DW-1:0] d, input logic r,
                        input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        if (v && in_ready && !f) sb_q.push_back(d);
        @(posedge clk);
        #1;
    endtask

    // Monitor: inputs are stable at the falling edge, so this sees exactly
    // what the next rising edge will act on.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_beat", {24'h0, out_data}, 32'hFFFF_FFFF);
                end else begin
                    check("out_data", {24'h0, out_data}, {24'h0, sb_q.pop_front()});
                end
            end
            if (!out_valid) begin
                check("idle_nop", {24'h0, out_data}, {24'h0, NOP});
                check("idle_occ", {30'h0, occupancy}, 32'd0);
            end
            if (flush) sb_q.delete();
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; stall_cnt_clr = 1'b0;
        #12;
        check("rst_valid", {31'h0, out_valid}, 32'd0);
        check("rst_data", {24'h0, out_data}, {24'h0, NOP});
        check("rst_ready", {31'h0, in_ready}, 32'd1);
        check("rst_occ", {30'h0, occupancy}, 32'd0);
        check("rst_stall", {29'h0, stall_cnt}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Streaming
        beat(1'b1, 8'h11, 1'b1, 1'b0);
        check("stream_occ1", {30'h0, occupancy}, 32'd1);
        check("stream_d1", {24'h0, out_data}, 32'h11);
        beat(1'b1, 8'h22, 1'b1, 1'b0);
        check("stream_occ2", {30'h0, occupancy}, 32'd1);
        check("stream_d2", {24'h0, out_data}, 32'h22);
        beat(1'b1, 8'h33, 1'b1, 1'b0);
        check("stream_d3", {24'h0, out_data}, 32'h33);
        beat(1'b0, 8'h00, 1'b1, 1'b0);
        check("stream_drain", {30'h0, occupancy}, 32'd0);
        check("stream_stall", {29'h0, stall_cnt}, 32'd0);

        // Back-pressure and skid
        beat(1'b1, 8'hA1, 1'b0, 1'b0);
        check("bp_occ1", {30'h0, occupancy}, 32'd1);
        check("bp_stall0", {29'h0, stall_cnt}, 32'd0);
        beat(1'b1, 8'hA2, 1'b0, 1'b0);
        check("bp_occ2", {30'h0, occupancy}, 32'd2);
        check("bp_rdy0", {31'h0, in_ready}, 32'd0);
        check("bp_stall1", {29'h0, stall_cnt}, 32'd1);
        beat(1'b0, 8'h00, 1'b0, 1'b0);
        check("bp_stall2", {29'h0, stall_cnt}, 32'd2);
        check("bp_hold", {24'h0, out_data}, 32'hA1);
        beat(1'b0, 8'h00, 1'b1, 1'b0);
        check("bp_rdy1", {31'h0, in_ready}, 32'd1);
        check("bp_skid_out", {24'h0, out_data}, 32'hA2);
        check("bp_occ_after", {30'h0, occupancy}, 32'd1);
        beat(1'b0, 8'h00, 1'b1, 1'b0);
        check("bp_empty", {30'h0, occupancy}, 32'd0);
        check("bp_stall_keep", {29'h0, stall_cnt}, 32'd2);

        // Flush with a full stage and a beat on offer
        beat(1'b1, 8'hB1, 1'b0, 1'b0);
        beat(1'b1, 8'hB2, 1'b0, 1'b0);
        check("fl_occ2", {30'h0, occupancy}, 32'd2);
        beat(1'b1, 8'hFF, 1'b0, 1'b1);
        check("fl_occ", {30'h0, occupancy}, 32'd0);
        check("fl_valid", {31'h0, out_valid}, 32'd0);
        check("fl_data", {24'h0, out_data}, {24'h0, NOP});
        check("fl_rdy", {31'h0, in_ready}, 32'd1);
        beat(1'b0, 8'h00, 1'b1, 1'b0);
        beat(1'b0, 8'h00, 1'b1, 1'b0);

        // Counter saturation and clear
        stall_cnt_clr = 1'b1;
        beat(1'b0, 8'h00, 1'b0, 1'b0);
        stall_cnt_clr = 1'b0;
        check("sat_clr0", {29'h0, stall_cnt}, 32'd0);
        beat(1'b1, 8'hC1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) beat(1'b0, 8'h00, 1'b0, 1'b0);
        check("sat_7", {29'h0, stall_cnt}, 32'd7);
        beat(1'b0, 8'h00, 1'b0, 1'b0);
        check("sat_hold", {29'h0, stall_cnt}, 32'd7);
        stall_cnt_clr = 1'b1;
        beat(1'b0, 8'h00, 1'b0, 1'b0);
        stall_cnt_clr = 1'b0;
        check("sat_clr", {29'h0, stall_cnt}, 32'd0);
        beat(1'b0, 8'h00, 1'b0, 1'b0);
        check("sat_restart", {29'h0, stall_cnt}, 32'd1);
        beat(1'b0, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset between edges with a full stage
        beat(1'b1, 8'hD1, 1'b0, 1'b0);
        beat(1'b1, 8'hD2, 1'b0, 1'b0);
        check("ar_occ2", {30'h0, occupancy}, 32'd2);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        sb_q.delete();
        check("ar_valid", {31'h0, out_valid}, 32'd0);
        check("ar_data", {24'h0, out_data}, {24'h0, NOP});
        check("ar_rdy", {31'h0, in_ready}, 32'd1);
        check("ar_occ", {30'h0, occupancy}, 32'd0);
        check("ar_stall", {29'h0, stall_cnt}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Random valid/ready/flush traffic
        for (int i = 0; i < 400; i++) begin
            beat(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < 4; i++) beat(1'b0, 8'h00, 1'b1, 1'b0);
        check("end_occ", {30'h0, occupancy}, 32'd0);
        check("end_sb", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
